// File: rtl/sr_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, NUM_BITS data bits, stop bit,
// with a valid/read handshake and sticky framing/overrun flags.
//
// state | meaning
// IDLE  | waiting for a start bit (serial_in = 0 on a strobe)
// DATA  | shifting in data bits, one per strobe
// STOP  | next strobe carries the stop bit; 1 loads the word, 0 flags framing
module sr_frame_rx #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                shift_enable,
    input  logic                data_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_valid,
    output logic                framing_error,
    output logic                overrun_error
);

    localparam int CW = $clog2(NUM_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       bit_cnt;
    logic [NUM_BITS-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '1;
            rx_data       <= '1;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            // Consumer handshake first; a same-edge load below overrides it.
            if (data_read && data_valid) begin
                data_valid    <= 1'b0;
                overrun_error <= 1'b0;
            end

            if (shift_enable) begin
                case (state)
                    IDLE: begin
                        if (!serial_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (SHIFT_MSB)
                            shreg <= {shreg[NUM_BITS-2:0], serial_in};
                        else
                            shreg <= {serial_in, shreg[NUM_BITS-1:1]};
                        if (bit_cnt == CW'(NUM_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (serial_in) begin
                            rx_data       <= shreg;
                            data_valid    <= 1'b1;
                            framing_error <= 1'b0;
                            if (data_valid && !data_read)
                                overrun_error <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_frame_rx.sv
// Bench for sr_frame_rx: MSB-first and LSB-first instances share stimulus;
// loaded words are checked against a scoreboard queue plus a flag model.
module tb_sr_frame_rx;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       shift_enable = 1'b0;
    logic       data_read = 1'b0;
    logic [7:0] rx_msb, rx_lsb;
    logic       dv_msb, dv_lsb, fe_msb, fe_lsb, oe_msb, oe_lsb;

    always #5 tb_clk = ~tb_clk;

    sr_frame_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_msb (
        .clk(tb_clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
        .data_read(data_read), .rx_data(rx_msb), .data_valid(dv_msb),
        .framing_error(fe_msb), .overrun_error(oe_msb)
    );

    sr_frame_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_lsb (
        .clk(tb_clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
        .data_read(data_read), .rx_data(rx_lsb), .data_valid(dv_lsb),
        .framing_error(fe_lsb), .overrun_error(oe_lsb)
    );

    typedef struct {
        logic [7:0] msb;
        logic [7:0] lsb;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int failures = 0;

    logic [7:0] m_msb = 8'hFF;
    logic [7:0] m_lsb = 8'hFF;
    logic       m_valid = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_oe = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // Apply one cycle of inputs, take the rising edge, then drop the strobes.
    task automatic cyc(input logic sin, input logic se, input logic rd);
        @(negedge tb_clk);
        serial_in    = sin;
        shift_enable = se;
        data_read    = rd;
        @(posedge tb_clk);
        #1;
        shift_enable = 1'b0;
        data_read    = 1'b0;
    endtask

    task automatic check_state(input string tag);
        @(negedge tb_clk);
        chk({tag, ".rx_msb"}, 32'(rx_msb), 32'(m_msb));
        chk({tag, ".rx_lsb"}, 32'(rx_lsb), 32'(m_lsb));
        chk({tag, ".valid"},  32'({dv_msb, dv_lsb}), 32'({m_valid, m_valid}));
        chk({tag, ".ferr"},   32'({fe_msb, fe_lsb}), 32'({m_fe, m_fe}));
        chk({tag, ".oerr"},   32'({oe_msb, oe_lsb}), 32'({m_oe, m_oe}));
    endtask

    task automatic gap_cycles(input int gap);
        for (int g = 0; g < gap; g++) cyc(g[0], 1'b0, 1'b0);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d, input logic stop,
                              input logic rd_on_stop, input int gap);
        exp_t e;
        cyc(1'b0, 1'b1, 1'b0);
        gap_cycles(gap);
        for (int i = 7; i >= 0; i--) begin
            cyc(d[i], 1'b1, 1'b0);
            gap_cycles(gap);
        end
        @(negedge tb_clk);
        chk({tag, ".pre_stop_rx"}, 32'(rx_msb), 32'(m_msb));
        cyc(stop, 1'b1, rd_on_stop);
        if (stop) begin
            if (m_valid && !rd_on_stop) m_oe = 1'b1;
            else if (m_valid && rd_on_stop) m_oe = 1'b0;
            m_msb   = d;
            m_lsb   = rev8(d);
            m_valid = 1'b1;
            m_fe    = 1'b0;
            e.msb = d;
            e.lsb = rev8(d);
            sbq.push_back(e);
        end else begin
            m_fe = 1'b1;
            if (rd_on_stop && m_valid) begin
                m_valid = 1'b0;
                m_oe    = 1'b0;
            end
        end
        if (stop) begin
            @(negedge tb_clk);
            if (sbq.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk({tag, ".sb_msb"}, 32'(rx_msb), 32'(e.msb));
                chk({tag, ".sb_lsb"}, 32'(rx_lsb), 32'(e.lsb));
            end
        end
        check_state(tag);
    endtask

    task automatic do_read(input string tag);
        cyc(1'b1, 1'b0, 1'b1);
        if (m_valid) begin
            m_valid = 1'b0;
            m_oe    = 1'b0;
        end
        check_state(tag);
    endtask

    task automatic model_reset();
        m_msb = 8'hFF; m_lsb = 8'hFF;
        m_valid = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        sbq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with active strobes and a start-like level
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        check_state("rst1");
        cyc(1'b0, 1'b1, 1'b0);
        check_state("rst2");
        @(negedge tb_clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        check_state("idle_ones");

        send_frame("gap_3c", 8'h3C, 1'b1, 1'b0, 3);
        do_read("read_3c");

        send_frame("good_a5", 8'hA5, 1'b1, 1'b0, 0);
        do_read("read_a5");
        do_read("read_idle");

        send_frame("ferr_0f", 8'h0F, 1'b0, 1'b0, 0);
        send_frame("good_11", 8'h11, 1'b1, 1'b0, 1);
        do_read("read_11");

        send_frame("ovr_01", 8'h01, 1'b1, 1'b0, 0);
        send_frame("ovr_02", 8'h02, 1'b1, 1'b0, 0);
        send_frame("ferr_keep_oe", 8'h55, 1'b0, 1'b0, 0);
        do_read("read_ovr");
        send_frame("rd_stop_03", 8'h03, 1'b1, 1'b1, 0);
        send_frame("rd_stop_04", 8'h04, 1'b1, 1'b1, 2);
        send_frame("ovr_again", 8'h9E, 1'b1, 1'b0, 0);
        send_frame("rd_stop_clr", 8'h6B, 1'b1, 1'b1, 0);
        do_read("read_6b");

        // Reset after four data bits abandons the partial frame
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        @(negedge tb_clk);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        @(negedge tb_clk);
        rst = 1'b0;
        model_reset();
        check_state("mid_rst");
        send_frame("post_rst_c3", 8'hC3, 1'b1, 1'b0, 0);
        send_frame("asym_d2", 8'hD2, 1'b1, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
